// File: rtl/alu_pkg.sv
// Shared types and small helpers for the multi-cycle ALU.
package alu_pkg;

  // Opcode encoding seen on operation_in.
  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpShl = 3'b101,
    OpShr = 3'b110,
    OpMul = 3'b111
  } alu_op_t;

  // Control FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StMul  = 2'b10
  } alu_state_t;

  // Signed overflow of A+B, judged from the operand and result sign bits.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Signed overflow of A-B, judged from the operand and result sign bits.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per clock.
module alu_mul_iter #(
  parameter int unsigned DATA_WIDTH = 11
) (
  input  logic                      clock_in,
  input  logic                      reset_n_in,
  input  logic                      load_in,
  input  logic [DATA_WIDTH-1:0]     A_in,
  input  logic [DATA_WIDTH-1:0]     B_in,
  output logic [2*DATA_WIDTH-1:0]   product_out,
  output logic                      finished_out
);

  localparam int unsigned CntWidth = $clog2(DATA_WIDTH + 1);

  logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
  logic [2*DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;

  // Load operands, then add the shifted multiplicand for each set multiplier bit.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load_in) begin
      acc_d    = '0;
      mcand_d  = {{DATA_WIDTH{1'b0}}, A_in};
      mplier_d = B_in;
      cnt_d    = CntWidth'(DATA_WIDTH);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CntWidth'(1);
    end
  end

  // Iteration state registers.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign product_out  = acc_q;
  // High while the final iteration is pending; product is complete after the next edge.
  assign finished_out = (cnt_q == CntWidth'(1));

endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU with start/done handshake and carry/overflow flags.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 11,
  parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clock_in,
  input  logic                  reset_n_in,
  input  logic                  start_in,
  input  logic [2:0]            operation_in,
  input  logic [DATA_WIDTH-1:0] A_in,
  input  logic [DATA_WIDTH-1:0] B_in,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  zero_indicator_out,
  output logic                  signal_bit_out,
  output logic                  carry_out,
  output logic                  overflow_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int unsigned Msb = DATA_WIDTH - 1;

  alu_state_t            state_q;
  alu_op_t               op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic                  mul_wb_q;
  logic [DATA_WIDTH-1:0] alu_q;
  logic                  zero_q, sign_q, carry_q, ovf_q, done_q;

  logic                    accept;
  logic                    mul_load;
  logic                    mul_finished;
  logic [2*DATA_WIDTH-1:0] mul_product;

  logic [DATA_WIDTH:0]    sum_ext, dif_ext, shl_ext, shr_ext;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   shamt_big;
  logic [DATA_WIDTH-1:0]  exec_res;
  logic                   exec_carry, exec_ovf;

  logic                  wb_en;
  logic [DATA_WIDTH-1:0] wb_res;
  logic                  wb_carry, wb_ovf;

  assign accept   = (state_q == StIdle) && start_in;
  // The multiplier takes operands straight from the ports on the accept edge.
  assign mul_load = accept && (alu_op_t'(operation_in) == OpMul);

  alu_mul_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mul (
    .clock_in    (clock_in),
    .reset_n_in  (reset_n_in),
    .load_in     (mul_load),
    .A_in        (A_in),
    .B_in        (B_in),
    .product_out (mul_product),
    .finished_out(mul_finished)
  );

  // Single-cycle datapath on the latched operands; arithmetic kept one bit wider for carry.
  always_comb begin
    sum_ext   = {1'b0, a_q} + {1'b0, b_q};
    dif_ext   = {1'b0, a_q} - {1'b0, b_q};
    shamt     = b_q[SHAMT_WIDTH-1:0];
    shamt_big = 32'(shamt) >= DATA_WIDTH;
    // Extra low/high bit catches the last bit shifted out; zero shift leaves it 0.
    shl_ext   = {1'b0, a_q} << shamt;
    shr_ext   = $signed({a_q, 1'b0}) >>> shamt;
    exec_res   = '0;
    exec_carry = 1'b0;
    exec_ovf   = 1'b0;
    unique case (op_q)
      OpAdd: begin
        exec_res   = sum_ext[Msb:0];
        exec_carry = sum_ext[DATA_WIDTH];
        exec_ovf   = add_ovf(a_q[Msb], b_q[Msb], sum_ext[Msb]);
      end
      OpSub: begin
        exec_res   = dif_ext[Msb:0];
        exec_carry = dif_ext[DATA_WIDTH];
        exec_ovf   = sub_ovf(a_q[Msb], b_q[Msb], dif_ext[Msb]);
      end
      OpAnd: exec_res = a_q & b_q;
      OpOr:  exec_res = a_q | b_q;
      OpXor: exec_res = a_q ^ b_q;
      OpShl: begin
        if (!shamt_big) begin
          exec_res   = shl_ext[Msb:0];
          exec_carry = shl_ext[DATA_WIDTH];
        end
      end
      OpShr: begin
        if (shamt_big) begin
          exec_res = {DATA_WIDTH{a_q[Msb]}};
        end else begin
          exec_res   = shr_ext[DATA_WIDTH:1];
          exec_carry = shr_ext[0];
        end
      end
      OpMul: begin
        exec_res = '0;
      end
    endcase
  end

  // Select which result is written back this edge: finished multiply or EXEC result.
  always_comb begin
    wb_en = mul_wb_q || (state_q == StExec);
    if (mul_wb_q) begin
      wb_res   = mul_product[Msb:0];
      wb_carry = |mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
      wb_ovf   = wb_carry;
    end else begin
      wb_res   = exec_res;
      wb_carry = exec_carry;
      wb_ovf   = exec_ovf;
    end
  end

  // Control FSM, operand capture and registered result/flags/done.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      a_q      <= '0;
      b_q      <= '0;
      mul_wb_q <= 1'b0;
      alu_q    <= '0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q   <= wb_en;
      mul_wb_q <= 1'b0;
      if (wb_en) begin
        alu_q   <= wb_res;
        zero_q  <= (wb_res == '0);
        sign_q  <= wb_res[Msb];
        carry_q <= wb_carry;
        ovf_q   <= wb_ovf;
      end
      unique case (state_q)
        StIdle: begin
          if (start_in) begin
            op_q    <= alu_op_t'(operation_in);
            a_q     <= A_in;
            b_q     <= B_in;
            state_q <= (alu_op_t'(operation_in) == OpMul) ? StMul : StExec;
          end
        end
        StExec: state_q <= StIdle;
        StMul: begin
          // Product settles on this edge; write it back on the next one.
          if (mul_finished) begin
            state_q  <= StIdle;
            mul_wb_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign alu_out            = alu_q;
  assign zero_indicator_out = zero_q;
  assign signal_bit_out     = sign_q;
  assign carry_out          = carry_q;
  assign overflow_out       = ovf_q;
  assign busy_out           = (state_q != StIdle);
  assign done_out           = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc at DATA_WIDTH=11: directed table, corner sequences, random ops.
module tb_alu_mc;

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpOr  = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpShl = 3'd5;
  localparam logic [2:0] OpShr = 3'd6;
  localparam logic [2:0] OpMul = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [10:0] a, b;
  logic [10:0] alu;
  logic        zero, sign, carry, ovf, busy, done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_mc #(
    .DATA_WIDTH(11)
  ) dut (
    .clock_in          (clk),
    .reset_n_in        (rst_n),
    .start_in          (start),
    .operation_in      (op),
    .A_in              (a),
    .B_in              (b),
    .alu_out           (alu),
    .zero_indicator_out(zero),
    .signal_bit_out    (sign),
    .carry_out         (carry),
    .overflow_out      (ovf),
    .busy_out          (busy),
    .done_out          (done)
  );

  typedef struct packed {
    logic [10:0] res;
    logic        z, s, c, v;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [10:0] a, b;
    exp_t        e;
    int          lat;
  } vec_t;

  function automatic void chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  // Reference: spec rules in plain integer arithmetic on an 11-bit word.
  function automatic exp_t model(input logic [2:0] mop, input logic [10:0] ma, input logic [10:0] mb);
    exp_t   e;
    int     ua, ub, sa, sb, r, n;
    longint p;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua >= 1024) ? ua - 2048 : ua;
    sb = (ub >= 1024) ? ub - 2048 : ub;
    n  = ub % 16;
    r  = 0;
    e  = '0;
    case (mop)
      OpAdd: begin
        r   = ua + ub;
        e.c = (r >= 2048);
        e.v = (sa + sb > 1023) || (sa + sb < -1024);
      end
      OpSub: begin
        r   = ua - ub;
        e.c = (ua < ub);
        e.v = (sa - sb > 1023) || (sa - sb < -1024);
      end
      OpAnd: r = ua & ub;
      OpOr:  r = ua | ub;
      OpXor: r = ua ^ ub;
      OpShl: begin
        if (n < 11) begin
          r   = ua * (2 ** n);
          e.c = ((r / 2048) % 2) == 1;
        end
      end
      OpShr: begin
        if (n >= 11) begin
          r = (sa < 0) ? 2047 : 0;
        end else begin
          r = sa >>> n;
          if (n > 0) e.c = ((ua >> (n - 1)) & 1) == 1;
        end
      end
      default: begin
        p   = longint'(ua) * longint'(ub);
        r   = int'(p % 2048);
        e.c = (p >= 2048);
        e.v = e.c;
      end
    endcase
    e.res = r[10:0];
    e.z   = (e.res == 11'd0);
    e.s   = e.res[10];
    return e;
  endfunction

  // Issue one op, scramble inputs after accept, wait (bounded) for done; lat=-1 on timeout.
  task automatic run_op(input logic [2:0] t_op, input logic [10:0] t_a, input logic [10:0] t_b,
                        output int lat);
    @(negedge clk);
    start = 1'b1;
    op    = t_op;
    a     = t_a;
    b     = t_b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'($urandom);
    a     = 11'($urandom);
    b     = 11'($urandom);
    lat   = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic check_out(input string tag, input exp_t e, input int lat, input int lat_exp);
    chk({tag, " latency"}, lat, lat_exp);
    chk({tag, " alu_out"}, alu, e.res);
    chk({tag, " zero"}, zero, e.z);
    chk({tag, " sign"}, sign, e.s);
    chk({tag, " carry"}, carry, e.c);
    chk({tag, " overflow"}, ovf, e.v);
  endtask

  vec_t vecs[14];
  int   lat, busy_cnt, done_cnt;
  exp_t e;

  initial begin
    //            op     a        b        res      z     s     c     v     lat
    vecs[0]  = '{OpAdd, 11'd1023, 11'd1,  '{11'd1024, 1'b0, 1'b1, 1'b0, 1'b1}, 1};
    vecs[1]  = '{OpSub, 11'd5,    11'd5,  '{11'd0,    1'b1, 1'b0, 1'b0, 1'b0}, 1};
    vecs[2]  = '{OpSub, 11'd3,    11'd5,  '{11'd2046, 1'b0, 1'b1, 1'b1, 1'b0}, 1};
    vecs[3]  = '{OpShl, 11'h401,  11'd1,  '{11'h002,  1'b0, 1'b0, 1'b1, 1'b0}, 1};
    vecs[4]  = '{OpShr, 11'h400,  11'd12, '{11'h7FF,  1'b0, 1'b1, 1'b0, 1'b0}, 1};
    vecs[5]  = '{OpShr, 11'h400,  11'd0,  '{11'h400,  1'b0, 1'b1, 1'b0, 1'b0}, 1};
    vecs[6]  = '{OpMul, 11'd45,   11'd45, '{11'd2025, 1'b0, 1'b1, 1'b0, 1'b0}, 12};
    vecs[7]  = '{OpMul, 11'd64,   11'd64, '{11'd0,    1'b1, 1'b0, 1'b1, 1'b1}, 12};
    vecs[8]  = '{OpAnd, 11'h5A5,  11'h0FF, '{11'h0A5, 1'b0, 1'b0, 1'b0, 1'b0}, 1};
    vecs[9]  = '{OpOr,  11'h500,  11'h0AA, '{11'h5AA, 1'b0, 1'b1, 1'b0, 1'b0}, 1};
    vecs[10] = '{OpXor, 11'h7FF,  11'h7FF, '{11'h000, 1'b1, 1'b0, 1'b0, 1'b0}, 1};
    vecs[11] = '{OpShl, 11'h001,  11'd10, '{11'h400,  1'b0, 1'b1, 1'b0, 1'b0}, 1};
    vecs[12] = '{OpShr, 11'h3FF,  11'd3,  '{11'h07F,  1'b0, 1'b0, 1'b1, 1'b0}, 1};
    vecs[13] = '{OpAdd, 11'h7FF,  11'h001, '{11'h000, 1'b1, 1'b0, 1'b1, 1'b0}, 1};

    rst_n = 1'b0;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset alu_out", alu, 0);
    chk("reset flags", {zero, sign, carry, ovf}, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, plus one-cycle done pulse and hold of results.
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check_out($sformatf("vec%0d", i), vecs[i].e, lat, vecs[i].lat);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d done pulse", i), done, 0);
      chk($sformatf("vec%0d hold", i), alu, vecs[i].e.res);
    end

    // MUL 45*45: busy width, latency, and an ADD start during busy is dropped.
    @(negedge clk);
    start = 1'b1;
    op    = OpMul;
    a     = 11'd45;
    b     = 11'd45;
    @(posedge clk);
    #1;
    start    = 1'b0;
    busy_cnt = busy ? 1 : 0;
    done_cnt = 0;
    lat      = -1;
    for (int c = 1; c <= 25; c++) begin
      if (c == 3) begin
        start = 1'b1;
        op    = OpAdd;
        a     = 11'd1;
        b     = 11'd1;
      end
      if (c == 4) start = 1'b0;
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = c;
      end
    end
    chk("mul45 busy cycles", busy_cnt, 11);
    chk("mul45 latency", lat, 12);
    chk("mul45 done count", done_cnt, 1);
    chk("mul45 alu_out", alu, 2025);

    // MUL 64*64, then ADD started on the done cycle.
    run_op(OpMul, 11'd64, 11'd64, lat);
    check_out("mul64", model(OpMul, 11'd64, 11'd64), lat, 12);
    start = 1'b1;
    op    = OpAdd;
    a     = 11'd7;
    b     = 11'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b busy", busy, 1);
    chk("b2b no early done", done, 0);
    @(posedge clk);
    #1;
    chk("b2b done", done, 1);
    chk("b2b alu_out", alu, 15);

    // Reset in the middle of a MUL: immediate clear, no done afterwards.
    @(negedge clk);
    start = 1'b1;
    op    = OpMul;
    a     = 11'd100;
    b     = 11'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset alu_out", alu, 0);
    chk("async reset flags", {zero, sign, carry, ovf, busy, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    chk("aborted mul done count", done_cnt, 0);
    run_op(OpAdd, 11'd2, 11'd2, lat);
    check_out("post reset add", model(OpAdd, 11'd2, 11'd2), lat, 1);
    chk("post reset add value", alu, 4);

    // Random ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  r_op;
      logic [10:0] r_a, r_b;
      r_op = 3'($urandom_range(0, 7));
      r_a  = 11'($urandom);
      r_b  = 11'($urandom);
      e    = model(r_op, r_a, r_b);
      run_op(r_op, r_a, r_b, lat);
      check_out($sformatf("rand%0d op%0d a=%0d b=%0d", i, r_op, r_a, r_b), e, lat,
                (r_op == OpMul) ? 12 : 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
